cmd_tx_pingpong_buf: RTL

Parametrised successor to the single-bank command TX memory. Holds two command-packet banks (ping-pong): the control side rewrites the shadow bank while the active bank streams out on a valid/ready interface with tlast. Committed packets swap in atomically at packet boundaries. Sits between the command builder and the GbE TX framer; one clock domain.

---
 rtl/cmd_tx_pingpong_buf_if.sv | 35 +++
 rtl/cmd_tx_pingpong_buf.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_tx_pingpong_buf_if.sv
// Bundles the command-write, commit, start and AXI-style TX stream signals of cmd_tx_pingpong_buf.
// Latency: none (wires only).
// Backpressure: tx_tready from the framer stalls the stream; the write/commit side is never stalled.
//
// master: command builder and TX framer side (drives writes, commit, start, tready).
// slave : the ping-pong buffer (drives stream outputs and status flags).
interface cmd_tx_pingpong_buf_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 10
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              commit;
    logic [ADDR_W:0]   commit_len;
    logic              tx_start;
    logic [DATA_W-1:0] tx_tdata;
    logic              tx_tvalid;
    logic              tx_tready;
    logic              tx_tlast;
    logic              busy;
    logic              swap_pending;
    logic              active_bank;
    logic              start_drop;

    modport master (
        output wr_en, wr_addr, wr_data, commit, commit_len, tx_start, tx_tready,
        input  tx_tdata, tx_tvalid, tx_tlast, busy, swap_pending, active_bank, start_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, commit_len, tx_start, tx_tready,
        output tx_tdata, tx_tvalid, tx_tlast, busy, swap_pending, active_bank, start_drop
    );
endinterface

// File: rtl/cmd_tx_pingpong_buf.sv
// Two-bank (ping-pong) command packet buffer: shadow bank is rewritten while the active bank streams out.
// Latency: first tx_tvalid two cycles after the accepted tx_start edge, then one word per cycle.
// Backpressure: tx_tready low holds the output word; a 2-entry skid FIFO absorbs the in-flight RAM read.
//
// Ports: clk, reset (sync, active-high) plus interface bus (slave):
//   wr_en/wr_addr/wr_data  write into the shadow bank (~active_bank)
//   commit/commit_len      shadow content complete; length saturates at 2**ADDR_W
//   tx_start               stream the active packet once
//   tx_tdata/tvalid/tready/tlast  output stream
//   busy, swap_pending, active_bank, start_drop (sticky)  status
module cmd_tx_pingpong_buf #(
    parameter int    DATA_W    = 9,
    parameter int    ADDR_W    = 10,
    parameter string RAM_STYLE = "block"
) (
    input logic                  clk,
    input logic                  reset,
    cmd_tx_pingpong_buf_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam int              LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q;
    logic                  active_bank_q;
    logic [1:0][LEN_W-1:0] len_q;
    logic                  swap_pending_q;
    logic                  start_drop_q;

    // Read side: word counter is one bit wider than the bank address so a
    // full-depth packet terminates instead of wrapping into the other bank.
    logic [LEN_W-1:0]  rd_cnt_q;
    logic              rd_vld_q;
    logic              rd_last_q;
    logic [DATA_W-1:0] rd_dat;

    logic [1:0][DATA_W-1:0] fifo_dat_q;
    logic [1:0]             fifo_last_q;
    logic                   fifo_wp_q;
    logic                   fifo_rp_q;
    logic [1:0]             fifo_cnt_q;

    logic             running;
    logic             fifo_vld;
    logic             head_last;
    logic             pop;
    logic             tlast_hs;
    logic [LEN_W-1:0] commit_len_sat;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] start_len;
    logic             swap;
    logic             start_ok;
    logic             start_bad;
    logic             space_ok;
    logic             rd_en;
    logic [ADDR_W:0]  mem_wa;
    logic [ADDR_W:0]  mem_ra;

    always_comb begin
        running        = (state_q == ST_RUN);
        fifo_vld       = (fifo_cnt_q != 2'd0);
        head_last      = fifo_last_q[fifo_rp_q];
        pop            = fifo_vld && bus.tx_tready;
        tlast_hs       = pop && head_last;
        commit_len_sat = (bus.commit_len > LEN_MAX) ? LEN_MAX : bus.commit_len;
        cur_len        = len_q[active_bank_q];

        // Idle commit swaps immediately; a commit while streaming waits for the
        // tlast handshake, which also covers a commit landing on that very edge.
        swap = (bus.commit && !running) || (tlast_hs && (swap_pending_q || bus.commit));

        // A same-cycle commit in idle wins: the start sees the freshly committed length.
        start_len = bus.commit ? commit_len_sat : cur_len;
        start_ok  = bus.tx_start && !running && (start_len != '0);
        start_bad = bus.tx_start && !start_ok;

        // Issue a read only if the FIFO can still hold it when it lands next
        // cycle, counting the read already in flight and this cycle's pop.
        space_ok = ({1'b0, fifo_cnt_q} + {2'b00, rd_vld_q}) <= (3'd1 + {2'b00, pop});
        rd_en    = running && (rd_cnt_q < cur_len) && space_ok;

        mem_wa = {~active_bank_q, bus.wr_addr};
        mem_ra = {active_bank_q, rd_cnt_q[ADDR_W-1:0]};
    end

    generate
        if (RAM_STYLE == "distributed") begin : g_ram_dist
            (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [2*DEPTH];
            always_ff @(posedge clk) begin
                if (bus.wr_en) begin
                    mem[mem_wa] <= bus.wr_data;
                end
                if (rd_en) begin
                    rd_dat <= mem[mem_ra];
                end
            end
        end else begin : g_ram_block
            (* ram_style = "block" *) logic [DATA_W-1:0] mem [2*DEPTH];
            always_ff @(posedge clk) begin
                if (bus.wr_en) begin
                    mem[mem_wa] <= bus.wr_data;
                end
                if (rd_en) begin
                    rd_dat <= mem[mem_ra];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            active_bank_q  <= 1'b0;
            len_q          <= '0;
            swap_pending_q <= 1'b0;
            start_drop_q   <= 1'b0;
            rd_cnt_q       <= '0;
            rd_vld_q       <= 1'b0;
            rd_last_q      <= 1'b0;
        end else begin
            if (bus.commit) begin
                len_q[~active_bank_q] <= commit_len_sat;
            end
            if (swap) begin
                active_bank_q  <= ~active_bank_q;
                swap_pending_q <= 1'b0;
            end else if (bus.commit && running) begin
                swap_pending_q <= 1'b1;
            end
            if (start_bad) begin
                start_drop_q <= 1'b1;
            end

            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_cnt_q  <= rd_cnt_q + 1'b1;
                rd_last_q <= (rd_cnt_q == cur_len - 1'b1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q  <= ST_RUN;
                        rd_cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (tlast_hs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output skid FIFO; the head entry drives the stream so it stays put while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_dat_q  <= '0;
            fifo_last_q <= '0;
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (rd_vld_q) begin
                fifo_dat_q[fifo_wp_q]  <= rd_dat;
                fifo_last_q[fifo_wp_q] <= rd_last_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (pop) begin
                fifo_rp_q <= ~fifo_rp_q;
            end
            case ({rd_vld_q, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.tx_tdata     = fifo_dat_q[fifo_rp_q];
    assign bus.tx_tvalid    = fifo_vld;
    assign bus.tx_tlast     = fifo_vld && head_last;
    assign bus.busy         = running;
    assign bus.swap_pending = swap_pending_q;
    assign bus.active_bank  = active_bank_q;
    assign bus.start_drop   = start_drop_q;
endmodule
